// File: rtl/exec_pkg.sv
// Shared types for the multi-cycle execute stage: opcodes, forwarding selects, FSM states.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_GT  = 4'd4,
    OP_EQ  = 4'd5,
    OP_MUL = 4'd6
  } op_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2
  } fwd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/exec_unit_mc_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W cycles per multiply.
// done is high during the final iteration; product is the value being committed on that edge.
module seq_mul #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] acc_step;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Accumulator plus the current partial product (multiplicand gated by multiplier LSB).
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Load operands on start, otherwise step one bit per cycle until the counter empties.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CW'(DATA_W);
    end else if (cnt_q != '0) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  // Multiplier state registers; reset clears any multiply in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done    = (cnt_q == CW'(1));
  assign product = acc_step;

endmodule

// File: rtl/exec_unit_mc.sv
// Execute stage: forwarded-operand ALU, branch resolve with one-slot squash, sticky halt,
// and an iterative multiplier that stalls upstream through in_ready while it runs.
module exec_unit_mc
  import exec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic [1:0]        fwd1_sel,
  input  logic [1:0]        fwd2_sel,
  input  logic [DATA_W-1:0] mem_value,
  input  logic [REG_AW-1:0] dst,
  input  logic [ADDR_W-1:0] target,
  input  logic              is_reg_write,
  input  logic              is_branch,
  input  logic              is_halt,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic              do_branch,
  output logic [ADDR_W-1:0] branch_addr,
  output logic              do_halt,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              out_valid_q, out_valid_d;
  logic              wb_en_q, wb_en_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic              do_branch_q, do_branch_d;
  logic [ADDR_W-1:0] branch_addr_q, branch_addr_d;
  logic              do_halt_q, do_halt_d;
  logic              busy_q, busy_d;
  logic              pend_wb_q, pend_wb_d;
  logic [REG_AW-1:0] pend_dst_q, pend_dst_d;
  logic              pend_br_q, pend_br_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

  logic [DATA_W-1:0] op1, op2, alu_res, mul_product;
  logic              transfer, mul_start, mul_done;

  assign in_ready = (state_q == ST_IDLE);
  assign transfer = in_valid && in_ready;

  // Operand muxes: EX forwards the result register, MEM forwards mem_value, else register file.
  always_comb begin
    case (fwd1_sel)
      FWD_EX:  op1 = result_q;
      FWD_MEM: op1 = mem_value;
      default: op1 = val1;
    endcase
    case (fwd2_sel)
      FWD_EX:  op2 = result_q;
      FWD_MEM: op2 = mem_value;
      default: op2 = val2;
    endcase
  end

  // Single-cycle ALU; MUL and undefined opcodes yield 0 here.
  always_comb begin
    case (op)
      OP_ADD:  alu_res = op1 + op2;
      OP_SUB:  alu_res = op1 - op2;
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_GT:   alu_res = {{(DATA_W-1){1'b0}}, (op1 > op2)};
      OP_EQ:   alu_res = {{(DATA_W-1){1'b0}}, (op1 == op2)};
      default: alu_res = '0;
    endcase
  end

  seq_mul #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (op1),
    .b       (op2),
    .done    (mul_done),
    .product (mul_product)
  );

  // Next-state and output logic; squash beats halt, halt beats normal issue.
  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
    out_valid_d   = 1'b0;
    wb_en_d       = 1'b0;
    wb_addr_d     = wb_addr_q;
    do_branch_d   = 1'b0;
    branch_addr_d = branch_addr_q;
    do_halt_d     = do_halt_q;
    busy_d        = busy_q;
    pend_wb_d     = pend_wb_q;
    pend_dst_d    = pend_dst_q;
    pend_br_d     = pend_br_q;
    pend_tgt_d    = pend_tgt_q;
    mul_start     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (transfer && !do_branch_q) begin
          if (is_halt) begin
            result_d      = alu_res;
            out_valid_d   = 1'b1;
            wb_en_d       = is_reg_write && !is_branch;
            wb_addr_d     = dst;
            do_branch_d   = is_branch && (alu_res != '0);
            branch_addr_d = target;
            do_halt_d     = 1'b1;
            state_d       = ST_HALTED;
          end else if (op == OP_MUL) begin
            mul_start  = 1'b1;
            busy_d     = 1'b1;
            pend_wb_d  = is_reg_write && !is_branch;
            pend_dst_d = dst;
            pend_br_d  = is_branch;
            pend_tgt_d = target;
            state_d    = ST_MUL;
          end else begin
            result_d      = alu_res;
            out_valid_d   = 1'b1;
            wb_en_d       = is_reg_write && !is_branch;
            wb_addr_d     = dst;
            do_branch_d   = is_branch && (alu_res != '0);
            branch_addr_d = target;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          result_d      = mul_product;
          out_valid_d   = 1'b1;
          wb_en_d       = pend_wb_q;
          wb_addr_d     = pend_dst_q;
          do_branch_d   = pend_br_q && (mul_product != '0);
          branch_addr_d = pend_tgt_q;
          busy_d        = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered stage state and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      result_q      <= '0;
      out_valid_q   <= 1'b0;
      wb_en_q       <= 1'b0;
      wb_addr_q     <= '0;
      do_branch_q   <= 1'b0;
      branch_addr_q <= '0;
      do_halt_q     <= 1'b0;
      busy_q        <= 1'b0;
      pend_wb_q     <= 1'b0;
      pend_dst_q    <= '0;
      pend_br_q     <= 1'b0;
      pend_tgt_q    <= '0;
    end else begin
      state_q       <= state_d;
      result_q      <= result_d;
      out_valid_q   <= out_valid_d;
      wb_en_q       <= wb_en_d;
      wb_addr_q     <= wb_addr_d;
      do_branch_q   <= do_branch_d;
      branch_addr_q <= branch_addr_d;
      do_halt_q     <= do_halt_d;
      busy_q        <= busy_d;
      pend_wb_q     <= pend_wb_d;
      pend_dst_q    <= pend_dst_d;
      pend_br_q     <= pend_br_d;
      pend_tgt_q    <= pend_tgt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign wb_en       = wb_en_q;
  assign wb_addr     = wb_addr_q;
  assign do_branch   = do_branch_q;
  assign branch_addr = branch_addr_q;
  assign do_halt     = do_halt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Bench for exec_unit_mc: directed vectors, scoreboard queues popped by output monitors.
module tb_exec_unit_mc;
  import exec_pkg::*;

  typedef struct {
    string       name;
    logic [15:0] result;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic        do_branch;
    logic [15:0] branch_addr;
    logic        do_halt;
  } exp_t;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [3:0]  op;
  logic [15:0] val1, val2, mem_value, target;
  logic [1:0]  fwd1_sel, fwd2_sel;
  logic [3:0]  dst;
  logic        is_reg_write, is_branch, is_halt;
  logic        out_valid, wb_en, do_branch, do_halt, busy;
  logic [15:0] result, branch_addr;
  logic [3:0]  wb_addr;

  logic        in_valid8, in_ready8;
  logic [3:0]  op8;
  logic [7:0]  val1_8, val2_8, mem_value8, target8, result8, branch_addr8;
  logic [3:0]  dst8, wb_addr8;
  logic        wr8, out_valid8, wb_en8, do_branch8, do_halt8, busy8;

  int   vec_count  = 0;
  int   fail_count = 0;
  exp_t sb[$];
  exp_t sb8[$];

  exec_unit_mc #(.DATA_W(16), .REG_AW(4), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .val1(val1), .val2(val2), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .mem_value(mem_value), .dst(dst), .target(target), .is_reg_write(is_reg_write),
    .is_branch(is_branch), .is_halt(is_halt), .out_valid(out_valid), .result(result),
    .wb_en(wb_en), .wb_addr(wb_addr), .do_branch(do_branch), .branch_addr(branch_addr),
    .do_halt(do_halt), .busy(busy)
  );

  exec_unit_mc #(.DATA_W(8), .REG_AW(4), .ADDR_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .val1(val1_8), .val2(val2_8), .fwd1_sel(2'd0), .fwd2_sel(2'd0),
    .mem_value(mem_value8), .dst(dst8), .target(target8), .is_reg_write(wr8),
    .is_branch(1'b0), .is_halt(1'b0), .out_valid(out_valid8), .result(result8),
    .wb_en(wb_en8), .wb_addr(wb_addr8), .do_branch(do_branch8), .branch_addr(branch_addr8),
    .do_halt(do_halt8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string n, input logic [15:0] r, input logic w,
                              input logic [3:0] a, input logic b, input logic [15:0] ba,
                              input logic h);
    exp_t e;
    e.name = n; e.result = r; e.wb_en = w; e.wb_addr = a;
    e.do_branch = b; e.branch_addr = ba; e.do_halt = h;
    return e;
  endfunction

  // Present one instruction for one clock edge, then drop in_valid.
  task automatic applyStimulus(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                               input logic [1:0] s1, input logic [1:0] s2, input logic [15:0] mv,
                               input logic [3:0] d, input logic [15:0] t,
                               input logic wr, input logic br, input logic hl);
    op = o; val1 = a; val2 = b; fwd1_sel = s1; fwd2_sel = s2; mem_value = mv;
    dst = d; target = t; is_reg_write = wr; is_branch = br; is_halt = hl;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Bounded wait for the stage to accept again.
  task automatic waitIdle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 64);
    if (!in_ready) checkOutput({name, "_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Monitor for the 16-bit unit: pop and compare on every valid output.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.name, "_result"}, 32'(result), 32'(e.result));
        checkOutput({e.name, "_wb_en"}, 32'(wb_en), 32'(e.wb_en));
        if (e.wb_en) checkOutput({e.name, "_wb_addr"}, 32'(wb_addr), 32'(e.wb_addr));
        checkOutput({e.name, "_do_branch"}, 32'(do_branch), 32'(e.do_branch));
        if (e.do_branch) checkOutput({e.name, "_branch_addr"}, 32'(branch_addr), 32'(e.branch_addr));
        checkOutput({e.name, "_do_halt"}, 32'(do_halt), 32'(e.do_halt));
      end
    end
  end

  // Monitor for the 8-bit unit.
  always @(negedge clk) begin
    if (rst && out_valid8) begin
      if (sb8.size() == 0) begin
        checkOutput("spurious_out_valid8", 32'(out_valid8), 32'd0);
      end else begin
        exp_t e;
        e = sb8.pop_front();
        checkOutput({e.name, "_result"}, 32'(result8), 32'(e.result[7:0]));
        checkOutput({e.name, "_wb_en"}, 32'(wb_en8), 32'(e.wb_en));
        checkOutput({e.name, "_wb_addr"}, 32'(wb_addr8), 32'(e.wb_addr));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    fail_count++;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; op = '0; val1 = '0; val2 = '0; fwd1_sel = '0; fwd2_sel = '0;
    mem_value = '0; dst = '0; target = '0; is_reg_write = 1'b0; is_branch = 1'b0; is_halt = 1'b0;
    in_valid8 = 1'b0; op8 = '0; val1_8 = '0; val2_8 = '0; mem_value8 = '0; dst8 = '0;
    target8 = '0; wr8 = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_do_halt", 32'(do_halt), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Wrapping add, then forwarding chain, then the remaining ALU ops
    sb.push_back(mk("add_wrap", 16'h0001, 1'b1, 4'd2, 1'b0, 16'h0, 1'b0));
    applyStimulus(OP_ADD, 16'hFFFF, 16'h0002, 2'd0, 2'd0, 16'h0, 4'd2, 16'h0, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk("add_3_4", 16'h0007, 1'b1, 4'd1, 1'b0, 16'h0, 1'b0));
    applyStimulus(OP_ADD, 16'h0003, 16'h0004, 2'd0, 2'd0, 16'h0, 4'd1, 16'h0, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk("sub_fwd_ex", 16'h0005, 1'b1, 4'd2, 1'b0, 16'h0, 1'b0));
    applyStimulus(OP_SUB, 16'h0099, 16'h0002, 2'd1, 2'd0, 16'h0, 4'd2, 16'h0, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk("add_fwd_mem", 16'h0101, 1'b1, 4'd3, 1'b0, 16'h0, 1'b0));
    applyStimulus(OP_ADD, 16'h0001, 16'h0055, 2'd0, 2'd2, 16'h0100, 4'd3, 16'h0, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk("add_fwd_rsvd", 16'd30, 1'b1, 4'd4, 1'b0, 16'h0, 1'b0));
    applyStimulus(OP_ADD, 16'd10, 16'd20, 2'd3, 2'd3, 16'h7777, 4'd4, 16'h0, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk("sub_wrap", 16'hFFFF, 1'b0, 4'd0, 1'b0, 16'h0, 1'b0));
    applyStimulus(OP_SUB, 16'h0000, 16'h0001, 2'd0, 2'd0, 16'h0, 4'd5, 16'h0, 1'b0, 1'b0, 1'b0);
    sb.push_back(mk("and", 16'hF000, 1'b1, 4'd6, 1'b0, 16'h0, 1'b0));
    applyStimulus(OP_AND, 16'hF0F0, 16'hFF00, 2'd0, 2'd0, 16'h0, 4'd6, 16'h0, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk("or", 16'h0FF0, 1'b1, 4'd7, 1'b0, 16'h0, 1'b0));
    applyStimulus(OP_OR, 16'h00F0, 16'h0F00, 2'd0, 2'd0, 16'h0, 4'd7, 16'h0, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk("gt_unsigned", 16'h0001, 1'b1, 4'd8, 1'b0, 16'h0, 1'b0));
    applyStimulus(OP_GT, 16'hFFFF, 16'h0001, 2'd0, 2'd0, 16'h0, 4'd8, 16'h0, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk("gt_false", 16'h0000, 1'b1, 4'd9, 1'b0, 16'h0, 1'b0));
    applyStimulus(OP_GT, 16'h0003, 16'h0005, 2'd0, 2'd0, 16'h0, 4'd9, 16'h0, 1'b1, 1'b0, 1'b0);
    sb.push_back(mk("undef_op", 16'h0000, 1'b1, 4'd10, 1'b0, 16'h0, 1'b0));
    applyStimulus(4'hF, 16'h1234, 16'h4321, 2'd0, 2'd0, 16'h0, 4'd10, 16'h0, 1'b1, 1'b0, 1'b0);

    // Multiply 300*300: busy/stall for 16 cycles, result on the 16th edge
    sb.push_back(mk("mul_300", 16'h5F90, 1'b1, 4'd5, 1'b0, 16'h0, 1'b0));
    applyStimulus(OP_MUL, 16'd300, 16'd300, 2'd0, 2'd0, 16'h0, 4'd5, 16'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mul_busy_c%0d", i), 32'(busy), 32'd1);
      checkOutput($sformatf("mul_stall_c%0d", i), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    checkOutput("mul_done_valid", 32'(out_valid), 32'd1);
    checkOutput("mul_done_busy", 32'(busy), 32'd0);
    checkOutput("mul_done_ready", 32'(in_ready), 32'd1);

    // Taken branch, shadow ADD squashed
    sb.push_back(mk("beq_taken", 16'h0001, 1'b0, 4'd0, 1'b1, 16'h0040, 1'b0));
    applyStimulus(OP_EQ, 16'd5, 16'd5, 2'd0, 2'd0, 16'h0, 4'd0, 16'h0040, 1'b0, 1'b1, 1'b0);
    applyStimulus(OP_ADD, 16'd1, 16'd1, 2'd0, 2'd0, 16'h0, 4'd3, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("squash_out_valid", 32'(out_valid), 32'd0);
    checkOutput("squash_wb_en", 32'(wb_en), 32'd0);
    checkOutput("squash_do_branch", 32'(do_branch), 32'd0);
    checkOutput("squash_result", 32'(result), 32'h0001);

    // Not-taken branch does not squash the next instruction
    sb.push_back(mk("beq_not_taken", 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0, 1'b0));
    applyStimulus(OP_EQ, 16'd5, 16'd6, 2'd0, 2'd0, 16'h0, 4'd0, 16'h0050, 1'b1, 1'b1, 1'b0);
    sb.push_back(mk("add_after_nt", 16'h0004, 1'b1, 4'd6, 1'b0, 16'h0, 1'b0));
    applyStimulus(OP_ADD, 16'd2, 16'd2, 2'd0, 2'd0, 16'h0, 4'd6, 16'h0, 1'b1, 1'b0, 1'b0);

    // Branch on a multiply result, resolved at completion, shadow squashed
    sb.push_back(mk("mul_branch", 16'h0006, 1'b0, 4'd2, 1'b1, 16'h1234, 1'b0));
    applyStimulus(OP_MUL, 16'd2, 16'd3, 2'd0, 2'd0, 16'h0, 4'd2, 16'h1234, 1'b1, 1'b1, 1'b0);
    waitIdle("mul_branch");
    applyStimulus(OP_ADD, 16'd9, 16'd9, 2'd0, 2'd0, 16'h0, 4'd3, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("mul_squash_valid", 32'(out_valid), 32'd0);
    checkOutput("mul_squash_result", 32'(result), 32'h0006);

    // Halt in the squash slot is ignored
    sb.push_back(mk("beq_before_halt", 16'h0001, 1'b0, 4'd0, 1'b1, 16'h0080, 1'b0));
    applyStimulus(OP_EQ, 16'd7, 16'd7, 2'd0, 2'd0, 16'h0, 4'd0, 16'h0080, 1'b0, 1'b1, 1'b0);
    applyStimulus(OP_ADD, 16'd1, 16'd1, 2'd0, 2'd0, 16'h0, 4'd1, 16'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("sq_halt_do_halt", 32'(do_halt), 32'd0);
    checkOutput("sq_halt_out_valid", 32'(out_valid), 32'd0);
    checkOutput("sq_halt_in_ready", 32'(in_ready), 32'd1);

    // 8-bit instance: 15*17 over 8 cycles
    sb8.push_back(mk("mul8_15_17", 16'h00FF, 1'b1, 4'd1, 1'b0, 16'h0, 1'b0));
    op8 = OP_MUL; val1_8 = 8'd15; val2_8 = 8'd17; dst8 = 4'd1; wr8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1 in_valid8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mul8_busy_c%0d", i), 32'(busy8), 32'd1);
    end
    @(negedge clk);
    checkOutput("mul8_done_valid", 32'(out_valid8), 32'd1);
    checkOutput("mul8_done_busy", 32'(busy8), 32'd0);

    // Reset in the middle of a multiply aborts it
    applyStimulus(OP_MUL, 16'd300, 16'd300, 2'd0, 2'd0, 16'h0, 4'd5, 16'h0, 1'b1, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_result", 32'(result), 32'd0);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    sb.push_back(mk("add_after_rst", 16'h0030, 1'b1, 4'd4, 1'b0, 16'h0, 1'b0));
    applyStimulus(OP_ADD, 16'h0010, 16'h0020, 2'd0, 2'd0, 16'h0, 4'd4, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("after_rst_busy", 32'(busy), 32'd0);

    // Halt: sticky, stalls, later instructions ignored
    sb.push_back(mk("halt", 16'h0002, 1'b1, 4'd7, 1'b0, 16'h0, 1'b1));
    applyStimulus(OP_ADD, 16'd1, 16'd1, 2'd0, 2'd0, 16'h0, 4'd7, 16'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_ADD, 16'd5, 16'd5, 2'd0, 2'd0, 16'h0, 4'd8, 16'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("halted_do_halt_%0d", i), 32'(do_halt), 32'd1);
      checkOutput($sformatf("halted_in_ready_%0d", i), 32'(in_ready), 32'd0);
      checkOutput($sformatf("halted_result_%0d", i), 32'(result), 32'h0002);
    end

    repeat (2) @(negedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("sb8_drained", 32'(sb8.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
